pipeline_control: RTL and testbench
===================================

# pipeline_control

Carries the decoded control bundles (`writeBackControl`, `memAccessControl`, `calculationControl`) from decode through the ID/EX, EX/MEM and MEM/WB pipeline registers. It also detects load-use hazards, squashes instructions on a taken branch, and generates ALU operand forwarding selects. It sits directly downstream of the opcode decoder and drives the EX, MEM and WB stage controls plus the stall/flush lines back to fetch.

## Interface
- `REG_ADDR_WIDTH`, 5, register-file address width
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `idValid` in 1: decode stage holds a real instruction; 0 means decoder outputs are don't-care
- `writeBackControl` in 2: {regWrite, memToReg} from decoder
- `memAccessControl` in 2: {memRead, memWrite} from decoder
- `calculationControl` in 4: {regDst, aluOp1, aluOp0, aluSrc} from decoder
- `idRs`, `idRt`, `idRd` in REG_ADDR_WIDTH: decode-stage register fields
- `branchTaken` in 1: beq in EX resolved taken (EX ALU zero & aluOp0)
- `exCalculationControl` out 4: ID/EX calculation bundle
- `memStageAccessControl` out 2: EX/MEM {memRead, memWrite}
- `wbStageWriteBackControl` out 2: MEM/WB {regWrite, memToReg}
- `exDest`, `memDest`, `wbDest` out REG_ADDR_WIDTH: destination register per stage
- `forwardA`, `forwardB` out 2: EX operand select; 00 register file, 10 EX/MEM result, 01 MEM/WB result
- `stall` out 1: hold PC and IF/ID this cycle
- `flushId` out 1: replace IF/ID contents with a bubble

## Operation
- Bubble: all control bits 0, destination 0, rs/rt 0. Bubbles never write and never match for hazards.
- ID/EX capture:
  - If `reset`, or `idValid`=0, or `stall`, or `branchTaken`: load a bubble.
  - Otherwise load the three bundles, `idRs`, `idRt`, and dest = regDst ? `idRd` : `idRt`.
  - Dest is forced to 0 when regWrite=0, so no x reaches hazard compares.
- EX/MEM captures the EX {WB, MEM} bundles and `exDest` every cycle; it is never stalled or flushed. The beq in EX proceeds with all-zero writes.
- MEM/WB captures the MEM WB bundle and `memDest` every cycle.
- Load-use: `stall` = `idValid` & exMemRead & `exDest`≠0 & (`exDest`==`idRs` | `exDest`==`idRt`) & !`branchTaken`.
- Branch: `flushId` = `branchTaken`.
- Branch beats load-use when both occur in the same cycle: `stall`=0 and `flushId`=1. The ID instruction is squashed, so no stall is needed.
- forwardA, checked in priority order against registered exRs:
  - 10 if memRegWrite & `memDest`≠0 & `memDest`==exRs
  - else 01 if wbRegWrite & `wbDest`≠0 & `wbDest`==exRs
  - else 00
- forwardB: same rule against exRt. EX/MEM always beats MEM/WB when both match.
- The decoder's default (unknown opcode) produces x. Upstream deasserts `idValid` for unknown opcodes; this block never propagates controls when `idValid`=0.

## Timing
- On reset, all pipeline registers clear to bubble. All outputs read 0 on the first cycle after reset: `stall`, `flushId` and `forwardA/B` are all 0.
- Latency:
  - Decode bundle to `exCalculationControl`: 1 cycle
  - Decode bundle to `memStageAccessControl`: 2 cycles
  - Decode bundle to `wbStageWriteBackControl`: 3 cycles
- `stall`, `flushId` and `forwardA/B` are combinational from registered state plus current ID inputs, with 0-cycle latency.
- A load-use `stall` lasts exactly one cycle, because the bubble it inserts clears the condition.
- Reset asserted mid-stream overrides stall/flush. All three stages become bubbles on the next edge.
- Back-to-back taken branches each produce one bubble in ID/EX and one `flushId` pulse.

## Structure
- A shared package holds:
  - Bundle bit-index constants (REG_WRITE=1, MEM_TO_REG=0, MEM_READ=1, MEM_WRITE=0, REG_DST=3, ALU_OP1=2, ALU_OP0=1, ALU_SRC=0)
  - Forward encodings FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - The all-zero bubble constants
- Sub-module `forwarding_unit`: purely combinational; inputs exRs/exRt plus the MEM and WB regWrite/dest; outputs forwardA/B.
- Pipeline registers and hazard/flush logic stay in `pipeline_control`.

## Test plan
- Reset, then R-format (0x0A, rs=1, rt=2, rd=3, idValid=1): next cycle `exCalculationControl`=4'b1100 and `exDest`=3. Two cycles later `wbStageWriteBackControl`=2'b10 and `wbDest`=3.
- lw into r5 (rt=5), then an instruction with rs=5: `stall`=1 for exactly one cycle, then ID/EX shows a bubble. On the following cycle the dependent instruction enters EX with forwardA=01.
- R-format writes r4, then R-format reads r4 as both rs and rt: the dependent instruction in EX sees forwardA=forwardB=10.
- Writes to r4 in two consecutive instructions, then a read of r4: forward=10 (EX/MEM priority). A write to r0 followed by a read of r0: forward=00.
- lw r5 in EX with an ID instruction reading r5, and `branchTaken`=1 in the same cycle: `stall`=0, `flushId`=1, and ID/EX is a bubble next cycle.
- `idValid`=0 with decoder outputs x: all downstream controls stay 0 with no x. Reset asserted mid-pipeline clears all stages within one cycle.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: bit positions, forwarding encodings and bubble values shared by the pipeline control block
package pipeline_control_pkg;
    localparam int REG_WRITE = 1;
    localparam int MEM_TO_REG = 0;
    localparam int MEM_READ = 1;
    localparam int MEM_WRITE = 0;
    localparam int REG_DST = 3;
    localparam int ALU_OP1 = 2;
    localparam int ALU_OP0 = 1;
    localparam int ALU_SRC = 0;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] WB_BUBBLE = 2'b00;
    localparam logic [1:0] MEM_BUBBLE = 2'b00;
    localparam logic [3:0] CALC_BUBBLE = 4'b0000;
endpackage

// File: rtl/pipeline_control_forwarding_unit.sv
// forwarding_unit: picks the EX operand source, with the younger EX/MEM result beating MEM/WB
module forwarding_unit
    import pipeline_control_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] exRs,
    input  logic [REG_ADDR_WIDTH-1:0] exRt,
    input  logic                      memRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] memDest,
    input  logic                      wbRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] wbDest,
    output logic [1:0]                forwardA,
    output logic [1:0]                forwardB
);
    logic mem_a, mem_b, wb_a, wb_b;
    always_comb begin
        mem_a = memRegWrite && memDest != '0 && memDest == exRs;
        mem_b = memRegWrite && memDest != '0 && memDest == exRt;
        wb_a = wbRegWrite && wbDest != '0 && wbDest == exRs;
        wb_b = wbRegWrite && wbDest != '0 && wbDest == exRt;
        forwardA = mem_a ? FWD_EXMEM : wb_a ? FWD_MEMWB : FWD_REG;
        forwardB = mem_b ? FWD_EXMEM : wb_b ? FWD_MEMWB : FWD_REG;
    end
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch squash and forwarding
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      idValid,
    input  logic [1:0]                writeBackControl,
    input  logic [1:0]                memAccessControl,
    input  logic [3:0]                calculationControl,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic [REG_ADDR_WIDTH-1:0] idRd,
    input  logic                      branchTaken,
    output logic [3:0]                exCalculationControl,
    output logic [1:0]                memStageAccessControl,
    output logic [1:0]                wbStageWriteBackControl,
    output logic [REG_ADDR_WIDTH-1:0] exDest,
    output logic [REG_ADDR_WIDTH-1:0] memDest,
    output logic [REG_ADDR_WIDTH-1:0] wbDest,
    output logic [1:0]                forwardA,
    output logic [1:0]                forwardB,
    output logic                      stall,
    output logic                      flushId
);
    logic [1:0] ex_wb, ex_mem, mem_wb;
    logic [REG_ADDR_WIDTH-1:0] ex_rs, ex_rt;
    logic bubble;
    // A squashed ID instruction needs no stall, so a taken branch suppresses it
    assign stall = idValid && ex_mem[MEM_READ] && exDest != '0
                   && (exDest == idRs || exDest == idRt) && !branchTaken;
    assign flushId = branchTaken;
    assign bubble = reset || !idValid || stall || branchTaken;
    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_wb <= WB_BUBBLE;
            ex_mem <= MEM_BUBBLE;
            exCalculationControl <= CALC_BUBBLE;
            ex_rs <= '0;
            ex_rt <= '0;
            exDest <= '0;
        end else begin
            ex_wb <= writeBackControl;
            ex_mem <= memAccessControl;
            exCalculationControl <= calculationControl;
            ex_rs <= idRs;
            ex_rt <= idRt;
            exDest <= !writeBackControl[REG_WRITE] ? '0 :
                      calculationControl[REG_DST] ? idRd : idRt;
        end
        if (reset) begin
            mem_wb <= WB_BUBBLE;
            memStageAccessControl <= MEM_BUBBLE;
            memDest <= '0;
            wbStageWriteBackControl <= WB_BUBBLE;
            wbDest <= '0;
        end else begin
            mem_wb <= ex_wb;
            memStageAccessControl <= ex_mem;
            memDest <= exDest;
            wbStageWriteBackControl <= mem_wb;
            wbDest <= memDest;
        end
    end
    forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
        .exRs(ex_rs),
        .exRt(ex_rt),
        .memRegWrite(mem_wb[REG_WRITE]),
        .memDest(memDest),
        .wbRegWrite(wbStageWriteBackControl[REG_WRITE]),
        .wbDest(wbDest),
        .forwardA(forwardA),
        .forwardB(forwardB)
    );
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: scoreboard bench; expectations are queued with a due cycle and checked on the falling edge
module tb_pipeline_control;
    localparam int S_CALC = 0, S_MEM = 1, S_WB = 2, S_EXD = 3, S_MEMD = 4, S_WBD = 5;
    localparam int S_FA = 6, S_FB = 7, S_STALL = 8, S_FLUSH = 9;
    typedef struct {
        int due;
        string tag;
        int sel;
        logic [4:0] val;
    } exp_t;
    logic clk = 0, reset = 1, idValid = 0, branchTaken = 0;
    logic [1:0] writeBackControl = 0, memAccessControl = 0;
    logic [3:0] calculationControl = 0;
    logic [4:0] idRs = 0, idRt = 0, idRd = 0;
    logic [3:0] exCalculationControl;
    logic [1:0] memStageAccessControl, wbStageWriteBackControl, forwardA, forwardB;
    logic [4:0] exDest, memDest, wbDest;
    logic stall, flushId;
    int cyc = 0, tests_run = 0, fails = 0;
    exp_t sb[$];
    pipeline_control #(.REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .idValid(idValid),
        .writeBackControl(writeBackControl), .memAccessControl(memAccessControl),
        .calculationControl(calculationControl),
        .idRs(idRs), .idRt(idRt), .idRd(idRd), .branchTaken(branchTaken),
        .exCalculationControl(exCalculationControl),
        .memStageAccessControl(memStageAccessControl),
        .wbStageWriteBackControl(wbStageWriteBackControl),
        .exDest(exDest), .memDest(memDest), .wbDest(wbDest),
        .forwardA(forwardA), .forwardB(forwardB), .stall(stall), .flushId(flushId)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [4:0] obs(input int sel);
        case (sel)
            S_CALC:  return {1'b0, exCalculationControl};
            S_MEM:   return {3'b0, memStageAccessControl};
            S_WB:    return {3'b0, wbStageWriteBackControl};
            S_EXD:   return exDest;
            S_MEMD:  return memDest;
            S_WBD:   return wbDest;
            S_FA:    return {3'b0, forwardA};
            S_FB:    return {3'b0, forwardB};
            S_STALL: return {4'b0, stall};
            default: return {4'b0, flushId};
        endcase
    endfunction
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    always @(negedge clk)
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due == cyc) begin
                check(sb[i].tag, obs(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
    task automatic expect_at(input int d, input string tag, input int sel, input logic [4:0] val);
        exp_t e;
        e.due = cyc + d;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic id(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                      input logic [3:0] calc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd);
        idValid = v;
        writeBackControl = wb;
        memAccessControl = mem;
        calculationControl = calc;
        idRs = rs;
        idRt = rt;
        idRd = rd;
    endtask
    task automatic r_fmt(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id(1'b1, 2'b10, 2'b00, 4'b1100, rs, rt, rd);
    endtask
    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        id(1'b1, 2'b11, 2'b10, 4'b0001, rs, rt, 5'd0);
    endtask
    task automatic nop();
        id(1'b0, 2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0);
    endtask
    task automatic drain();
        nop();
        repeat (4) tick();
    endtask
    initial begin
        repeat (2) tick();
        reset = 0;
        expect_at(0, "rst_calc", S_CALC, 0);
        expect_at(0, "rst_mem", S_MEM, 0);
        expect_at(0, "rst_wb", S_WB, 0);
        expect_at(0, "rst_exd", S_EXD, 0);
        expect_at(0, "rst_fa", S_FA, 0);
        expect_at(0, "rst_fb", S_FB, 0);
        expect_at(0, "rst_stall", S_STALL, 0);
        expect_at(0, "rst_flush", S_FLUSH, 0);
        // R-format latency through all stages
        r_fmt(1, 2, 3);
        expect_at(1, "r_calc", S_CALC, 4'b1100);
        expect_at(1, "r_exd", S_EXD, 3);
        expect_at(2, "r_mem", S_MEM, 0);
        expect_at(2, "r_memd", S_MEMD, 3);
        expect_at(3, "r_wb", S_WB, 2'b10);
        expect_at(3, "r_wbd", S_WBD, 3);
        tick();
        drain();
        // store has regWrite=0, so its dest must read 0
        id(1'b1, 2'b00, 2'b01, 4'b0001, 5'd1, 5'd5, 5'd9);
        expect_at(1, "sw_exd", S_EXD, 0);
        expect_at(2, "sw_mem", S_MEM, 2'b01);
        tick();
        drain();
        // load-use: one stall cycle, bubble, then MEM/WB forward
        lw(0, 5);
        expect_at(1, "lw_exd", S_EXD, 5);
        tick();
        r_fmt(5, 6, 7);
        expect_at(0, "lu_stall", S_STALL, 1);
        expect_at(0, "lu_flush", S_FLUSH, 0);
        tick();
        expect_at(0, "lu_stall_end", S_STALL, 0);
        expect_at(0, "lu_bub_calc", S_CALC, 0);
        expect_at(0, "lu_bub_exd", S_EXD, 0);
        expect_at(0, "lu_lw_mem", S_MEM, 2'b10);
        tick();
        nop();
        expect_at(0, "lu_fa", S_FA, 2'b01);
        expect_at(0, "lu_fb", S_FB, 2'b00);
        expect_at(0, "lu_dep_calc", S_CALC, 4'b1100);
        expect_at(0, "lu_dep_exd", S_EXD, 7);
        drain();
        // EX/MEM forward to both operands
        r_fmt(1, 2, 4);
        tick();
        r_fmt(4, 4, 8);
        expect_at(0, "em_nostall", S_STALL, 0);
        tick();
        nop();
        expect_at(0, "em_fa", S_FA, 2'b10);
        expect_at(0, "em_fb", S_FB, 2'b10);
        drain();
        // two writers of r4: EX/MEM wins
        r_fmt(1, 2, 4);
        tick();
        r_fmt(9, 9, 4);
        tick();
        r_fmt(4, 10, 11);
        tick();
        nop();
        expect_at(0, "prio_fa", S_FA, 2'b10);
        expect_at(0, "prio_fb", S_FB, 2'b00);
        drain();
        // writes to r0 are never forwarded
        r_fmt(1, 2, 0);
        expect_at(1, "r0_exd", S_EXD, 0);
        tick();
        r_fmt(0, 0, 12);
        tick();
        nop();
        expect_at(0, "r0_fa", S_FA, 0);
        expect_at(0, "r0_fb", S_FB, 0);
        drain();
        // branch in the same cycle as load-use: flush wins
        lw(0, 5);
        tick();
        r_fmt(5, 1, 2);
        branchTaken = 1;
        expect_at(0, "br_stall", S_STALL, 0);
        expect_at(0, "br_flush", S_FLUSH, 1);
        tick();
        branchTaken = 0;
        nop();
        expect_at(0, "br_bub_calc", S_CALC, 0);
        expect_at(0, "br_bub_exd", S_EXD, 0);
        expect_at(0, "br_lw_mem", S_MEM, 2'b10);
        drain();
        // back-to-back taken branches
        r_fmt(1, 2, 3);
        branchTaken = 1;
        expect_at(0, "bb_flush0", S_FLUSH, 1);
        expect_at(1, "bb_flush1", S_FLUSH, 1);
        expect_at(1, "bb_exd0", S_EXD, 0);
        expect_at(2, "bb_exd1", S_EXD, 0);
        expect_at(2, "bb_calc1", S_CALC, 0);
        tick();
        r_fmt(4, 5, 6);
        tick();
        branchTaken = 0;
        drain();
        // idValid low with unknown decoder outputs
        id(1'b0, 2'bxx, 2'bxx, 4'bxxxx, 5'd3, 5'd3, 5'd3);
        expect_at(1, "inv_calc", S_CALC, 0);
        expect_at(1, "inv_exd", S_EXD, 0);
        expect_at(2, "inv_mem", S_MEM, 0);
        expect_at(3, "inv_wb", S_WB, 0);
        expect_at(0, "inv_stall", S_STALL, 0);
        repeat (4) tick();
        // reset mid-stream clears every stage in one edge
        r_fmt(1, 2, 4);
        tick();
        r_fmt(4, 4, 6);
        tick();
        lw(0, 7);
        reset = 1;
        tick();
        reset = 0;
        nop();
        expect_at(0, "mr_calc", S_CALC, 0);
        expect_at(0, "mr_mem", S_MEM, 0);
        expect_at(0, "mr_wb", S_WB, 0);
        expect_at(0, "mr_exd", S_EXD, 0);
        expect_at(0, "mr_memd", S_MEMD, 0);
        expect_at(0, "mr_wbd", S_WBD, 0);
        expect_at(0, "mr_fa", S_FA, 0);
        expect_at(0, "mr_fb", S_FB, 0);
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
